// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter multiplexing N_REQ asynchronous 4-phase requesters onto one
// downstream 4-phase channel, with input synchronisers and a sticky ack-wait timeout.
module hs_rr_arbiter #(
  parameter int N_REQ       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255,
  localparam int GW = $clog2(N_REQ),
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_in_i,
  output logic [N_REQ-1:0] ack_in_o,
  output logic             req_out_o,
  input  logic             ack_out_i,
  output logic [GW-1:0]    grant_o,
  output logic             busy_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK_HI, WAIT_REQ_LO, WAIT_ACK_LO} state_t;

  logic [SYNC_STAGES-1:0][N_REQ-1:0] r_req_sync;
  logic [SYNC_STAGES-1:0]            r_ack_sync;
  logic [N_REQ-1:0]                  w_req_s;
  logic                              w_ack_s;

  state_t           r_state, w_state_nx;
  logic             r_req_out, w_req_out_nx;
  logic [N_REQ-1:0] r_ack_in, w_ack_in_nx;
  logic [GW-1:0]    r_grant, w_grant_nx;
  logic [GW-1:0]    r_ptr, w_ptr_nx;
  logic [CW-1:0]    r_cnt;
  logic             r_timeout;
  logic             w_found;
  logic [GW-1:0]    w_g;
  logic             w_wait, w_wait_entry;

  assign w_req_s = r_req_sync[SYNC_STAGES-1];
  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_req_sync <= '0;
      r_ack_sync <= '0;
    end else begin
      r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], req_in_i};
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_out_i};
    end
  end

  // First pending request at or after the pointer, wrapping around.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_g     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!w_found && w_req_s[idx]) begin
        w_found = 1'b1;
        w_g     = GW'(idx);
      end
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_req_out_nx = r_req_out;
    w_ack_in_nx  = r_ack_in;
    w_grant_nx   = r_grant;
    w_ptr_nx     = r_ptr;
    case (r_state)
      // A still-high downstream ack (e.g. after reset mid-handshake) blocks new grants.
      IDLE: if (w_found && !w_ack_s) begin
        w_grant_nx   = w_g;
        w_req_out_nx = 1'b1;
        w_state_nx   = WAIT_ACK_HI;
      end
      WAIT_ACK_HI: if (w_ack_s) begin
        w_ack_in_nx = N_REQ'(1) << r_grant;
        w_state_nx  = WAIT_REQ_LO;
      end
      WAIT_REQ_LO: if (!w_req_s[r_grant]) begin
        w_req_out_nx = 1'b0;
        w_state_nx   = WAIT_ACK_LO;
      end
      WAIT_ACK_LO: if (!w_ack_s) begin
        w_ack_in_nx = '0;
        w_ptr_nx    = (r_grant == GW'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
        w_state_nx  = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign w_wait       = (r_state == WAIT_ACK_HI) || (r_state == WAIT_ACK_LO);
  assign w_wait_entry = (w_state_nx != r_state) &&
                        ((w_state_nx == WAIT_ACK_HI) || (w_state_nx == WAIT_ACK_LO));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_req_out <= 1'b0;
      r_ack_in  <= '0;
      r_grant   <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_req_out <= w_req_out_nx;
      r_ack_in  <= w_ack_in_nx;
      r_grant   <= w_grant_nx;
      r_ptr     <= w_ptr_nx;
      if (w_wait_entry)
        r_cnt <= '0;
      else if (w_wait && r_cnt != CW'(TIMEOUT))
        r_cnt <= r_cnt + 1'b1;
      // Flag only; the handshake keeps waiting for the late ack.
      if (w_wait && r_cnt == CW'(TIMEOUT))
        r_timeout <= 1'b1;
    end
  end

  assign req_out_o = r_req_out;
  assign ack_in_o  = r_ack_in;
  assign grant_o   = r_grant;
  assign busy_o    = (r_state != IDLE);
  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Scoreboarded bench for hs_rr_arbiter: expected grants queued at stimulus time and
// checked on every req_out_o rise; plus latency, timeout and reset scenarios.
module tb_hs_rr_arbiter;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic [N-1:0] req_in = '0;
  logic         ack_out = 1'b0;
  logic [N-1:0] ack_in_o;
  logic         req_out_o;
  logic [1:0]   grant_o;
  logic         busy_o;
  logic         timeout_o;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  logic prev_req = 1'b0;

  hs_rr_arbiter #(.N_REQ(N), .SYNC_STAGES(2), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_in_i(req_in), .ack_in_o(ack_in_o),
    .req_out_o(req_out_o), .ack_out_i(ack_out), .grant_o(grant_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every grant the DUT issues must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_i) prev_req = 1'b0;
    else begin
      if (req_out_o && !prev_req) begin
        if (exp_q.size() == 0) chk("unexp_grant", exp_q.size(), 1);
        else chk("sb_grant", grant_o, exp_q.pop_front());
      end
      chk("onehot_ack", $countones(ack_in_o) <= 1, 1);
      prev_req = req_out_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  task automatic wait_req(input logic v, input string tag);
    int n = 0;
    while (req_out_o !== v && n < 60) begin @(negedge clk); n++; end
    chk(tag, req_out_o, v);
  endtask

  task automatic wait_ack(input logic [N-1:0] v, input string tag);
    int n = 0;
    while (ack_in_o !== v && n < 60) begin @(negedge clk); n++; end
    chk(tag, ack_in_o, v);
  endtask

  task automatic wait_grant(input int k);
    exp_q.push_back(k);
    wait_req(1'b1, "req_rise");
    chk("grant", grant_o, k);
    chk("busy_hi", busy_o, 1);
  endtask

  task automatic finish_hs(input int k, input logic [N-1:0] drop, input logic [N-1:0] raise);
    logic [N-1:0] oh;
    oh = 3'b001 << k;
    ack_out = 1'b1;
    wait_ack(oh, "ack_rise");
    req_in = req_in & ~drop;
    wait_req(1'b0, "req_fall");
    ack_out = 1'b0;
    wait_ack('0, "ack_fall");
    chk("busy_idle", busy_o, 0);
    req_in = req_in | raise;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, req_out_o, 0);
    chk({tag, "_ack"}, ack_in_o, 0);
    chk({tag, "_gnt"}, grant_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_to"}, timeout_o, 0);
  endtask

  initial begin
    // 1: reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_in  = N'($urandom_range(0, 7));
      ack_out = 1'($urandom_range(0, 1));
      chk_zero("rst");
    end
    req_in = '0; ack_out = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    repeat (3) @(negedge clk);

    // 2: exact latencies on a single requester
    exp_q.push_back(1);
    req_in = 3'b010;
    repeat (2) @(negedge clk);
    chk("lat_req_early", req_out_o, 0);
    @(negedge clk);
    chk("lat_req", req_out_o, 1);
    chk("lat_gnt", grant_o, 1);
    ack_out = 1'b1;
    repeat (2) @(negedge clk);
    chk("lat_ack_early", ack_in_o, 0);
    @(negedge clk);
    chk("lat_ack", ack_in_o, 3'b010);
    req_in = '0;
    repeat (2) @(negedge clk);
    chk("lat_fall_early", req_out_o, 1);
    @(negedge clk);
    chk("lat_fall", req_out_o, 0);
    ack_out = 1'b0;
    repeat (3) @(negedge clk);
    chk("lat_ackfall", ack_in_o, 0);
    chk("lat_idle", busy_o, 0);

    // 3: full contention; pointer sits at 2 after serving 1
    req_in = 3'b111;
    begin
      int order[7] = '{2, 0, 1, 2, 0, 1, 2};
      for (int i = 0; i < 7; i++) begin
        logic [N-1:0] oh;
        oh = 3'b001 << order[i];
        wait_grant(order[i]);
        if (i == 6) finish_hs(order[i], 3'b111, 3'b000);
        else        finish_hs(order[i], oh, oh);
      end
    end
    repeat (6) @(negedge clk);
    chk("rr_quiet", req_out_o, 0);

    // 4: timeout on a missing downstream ack
    req_in = 3'b001;
    wait_grant(0);
    chk("to_start", timeout_o, 0);
    repeat (5) @(negedge clk);
    chk("to_early", timeout_o, 0);
    repeat (6) @(negedge clk);
    chk("to_set", timeout_o, 1);
    repeat (10) @(negedge clk);
    chk("to_sticky", timeout_o, 1);
    chk("to_still_wait", busy_o, 1);
    finish_hs(0, 3'b001, 3'b000);
    chk("to_after_hs", timeout_o, 1);
    repeat (3) @(negedge clk);

    // 5: reset in WAIT_REQ_LO with ack high and request held
    req_in = 3'b001;
    wait_grant(0);
    ack_out = 1'b1;
    wait_ack(3'b001, "r5_ack");
    #2 rst_i = 1'b1;
    #1 chk_zero("r5_async");
    @(negedge clk);
    chk_zero("r5_hold");
    @(negedge clk);
    rst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("r5_noreq", req_out_o, 0);
    end
    exp_q.push_back(0);
    ack_out = 1'b0;
    repeat (2) @(negedge clk);
    chk("r5_wait_rtz", req_out_o, 0);
    wait_req(1'b1, "r5_req");
    chk("r5_gnt", grant_o, 0);
    finish_hs(0, 3'b001, 3'b000);
    repeat (3) @(negedge clk);

    // 6: serve 2, request 0 arrives mid-handshake, pointer wraps to 0
    req_in = 3'b100;
    wait_grant(2);
    req_in[0] = 1'b1;
    finish_hs(2, 3'b100, 3'b000);
    wait_grant(0);
    finish_hs(0, 3'b001, 3'b000);
    repeat (6) @(negedge clk);

    chk("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
